// File: rtl/uart_rx_line_capture.sv
// uart_rx_line_capture
//
// Assembles bytes from a UART receiver into one text line of up to 32 characters
// and presents it to a consumer as a fixed 34-byte record.
//
// The record always ends in CR/LF (bytes 32..33). Unused payload bytes read as
// spaces. A skip byte (CR by default) is dropped on arrival. A terminator byte
// (LF by default) closes a non-empty line. Characters past the 32nd are thrown
// away, and the presented line is then flagged as truncated. While a line is on
// offer, every incoming byte is discarded and reported with a one-cycle pulse.
//
// Ports
//   i_clk_20mhz   in   1    clock; all state updates on the rising edge
//   i_rst_20mhz   in   1    asynchronous active-low reset
//   i_rx_data     in   8    received byte
//   i_rx_valid    in   1    one-cycle qualifier for i_rx_data (no backpressure)
//   i_line_ack    in   1    consumer releases the presented line
//   o_line_ascii  out  272  line record; byte 0 (first char) in [271:264]
//   o_line_valid  out  1    a completed line is held on o_line_ascii
//   o_line_len    out  6    stored payload characters, 0..32
//   o_line_trunc  out  1    presented line lost characters past 32
//   o_rx_drop     out  1    pulse per byte discarded while a line is presented

module uart_rx_line_capture #(
   parameter logic [7:0] p_term_char = 8'h0A,
   parameter logic [7:0] p_skip_char = 8'h0D
) (
   input  logic         i_clk_20mhz,
   input  logic         i_rst_20mhz,
   input  logic [7:0]   i_rx_data,
   input  logic         i_rx_valid,
   output logic [271:0] o_line_ascii,
   output logic         o_line_valid,
   input  logic         i_line_ack,
   output logic [5:0]   o_line_len,
   output logic         o_line_trunc,
   output logic         o_rx_drop
);

   typedef enum logic [1:0] {
      ST_RXLINE_ACCUM   = 2'd0,
      ST_RXLINE_DISCARD = 2'd1,
      ST_RXLINE_PRESENT = 2'd2
   } state_e;

   localparam logic [5:0]        MaxChars  = 6'd32;
   localparam logic [31:0][7:0] BlankLine = {32{8'h20}};

   state_e           state_q, state_d;
   logic [5:0]       count_q, count_d;
   // Element 31 holds character 0 so the packed array maps straight onto the
   // output with the first character in the top byte.
   logic [31:0][7:0] buf_q, buf_d;
   logic             line_valid_q, line_valid_d;
   logic [5:0]       line_len_q, line_len_d;
   logic             line_trunc_q, line_trunc_d;
   logic             rx_drop_q, rx_drop_d;

   logic is_skip;
   logic is_term;

   assign is_skip = (i_rx_data == p_skip_char);
   assign is_term = (i_rx_data == p_term_char);

   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      buf_d        = buf_q;
      line_valid_d = line_valid_q;
      line_len_d   = line_len_q;
      line_trunc_d = line_trunc_q;
      rx_drop_d    = 1'b0;

      case (state_q)
         ST_RXLINE_ACCUM: begin
            // The skip byte takes priority. If it equals the terminator, it is still just dropped.
            if (i_rx_valid && !is_skip) begin
               if (is_term) begin
                  // Empty lines are swallowed rather than presented.
                  if (count_q != 6'd0) begin
                     state_d      = ST_RXLINE_PRESENT;
                     line_valid_d = 1'b1;
                     line_len_d   = count_q;
                     line_trunc_d = 1'b0;
                  end
               end else if (count_q < MaxChars) begin
                  buf_d[5'd31 - count_q[4:0]] = i_rx_data;
                  count_d                     = count_q + 6'd1;
               end else begin
                  state_d = ST_RXLINE_DISCARD;
               end
            end
         end

         ST_RXLINE_DISCARD: begin
            if (i_rx_valid && is_term) begin
               state_d      = ST_RXLINE_PRESENT;
               line_valid_d = 1'b1;
               line_len_d   = MaxChars;
               line_trunc_d = 1'b1;
            end
         end

         ST_RXLINE_PRESENT: begin
            // A byte that arrives in the ack cycle is still dropped.
            rx_drop_d = i_rx_valid;
            if (i_line_ack) begin
               state_d      = ST_RXLINE_ACCUM;
               count_d      = 6'd0;
               buf_d        = BlankLine;
               line_valid_d = 1'b0;
               line_len_d   = 6'd0;
               line_trunc_d = 1'b0;
            end
         end

         default: begin
            state_d      = ST_RXLINE_ACCUM;
            count_d      = 6'd0;
            buf_d        = BlankLine;
            line_valid_d = 1'b0;
            line_len_d   = 6'd0;
            line_trunc_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clk_20mhz or negedge i_rst_20mhz) begin
      if (!i_rst_20mhz) begin
         state_q      <= ST_RXLINE_ACCUM;
         count_q      <= 6'd0;
         buf_q        <= BlankLine;
         line_valid_q <= 1'b0;
         line_len_q   <= 6'd0;
         line_trunc_q <= 1'b0;
         rx_drop_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         buf_q        <= buf_d;
         line_valid_q <= line_valid_d;
         line_len_q   <= line_len_d;
         line_trunc_q <= line_trunc_d;
         rx_drop_q    <= rx_drop_d;
      end
   end

   assign o_line_ascii = {buf_q, 8'h0D, 8'h0A};
   assign o_line_valid = line_valid_q;
   assign o_line_len   = line_len_q;
   assign o_line_trunc = line_trunc_q;
   assign o_rx_drop    = rx_drop_q;

endmodule

// File: tb/tb_uart_rx_line_capture.sv
// Directed bench for uart_rx_line_capture: a per-cycle vector table plus
// hand-written sequences for truncation, back-to-back traffic and async reset.

module tb_uart_rx_line_capture;

   logic         clk;
   logic         rst_n;
   logic [7:0]   rx_data;
   logic         rx_valid;
   logic         line_ack;
   logic [271:0] line_ascii;
   logic         line_valid;
   logic [5:0]   line_len;
   logic         line_trunc;
   logic         rx_drop;

   uart_rx_line_capture dut (
      .i_clk_20mhz  (clk),
      .i_rst_20mhz  (rst_n),
      .i_rx_data    (rx_data),
      .i_rx_valid   (rx_valid),
      .o_line_ascii (line_ascii),
      .o_line_valid (line_valid),
      .i_line_ack   (line_ack),
      .o_line_len   (line_len),
      .o_line_trunc (line_trunc),
      .o_rx_drop    (rx_drop)
   );

   initial clk = 1'b0;
   always #25 clk = ~clk;

   localparam logic [271:0] BLANK = {{32{8'h20}}, 8'h0D, 8'h0A};
   localparam logic [271:0] HI    = {8'h48, 8'h49, {30{8'h20}}, 8'h0D, 8'h0A};
   localparam logic [271:0] LQ    = {8'h51, {31{8'h20}}, 8'h0D, 8'h0A};
   localparam logic [271:0] LC    = {8'h43, {31{8'h20}}, 8'h0D, 8'h0A};
   localparam logic [271:0] LA32  = {{32{8'h41}}, 8'h0D, 8'h0A};
   localparam logic [271:0] L0123 = {8'h30, 8'h31, 8'h32, 8'h33, {28{8'h20}}, 8'h0D, 8'h0A};

   typedef struct {
      logic         v;
      logic [7:0]   d;
      logic         a;
      logic         e_valid;
      logic [5:0]   e_len;
      logic         e_trunc;
      logic         e_drop;
      logic         do_ascii;
      logic [271:0] e_ascii;
   } vec_t;

   localparam int NVEC = 17;
   vec_t tbl [NVEC];

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [271:0] act, input logic [271:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", name, act, exp);
      end
   endtask

   task automatic chk_out(input string name, input logic ev, input logic [5:0] el,
                          input logic et, input logic ed);
      chk({name, ".valid"}, 272'(line_valid), 272'(ev));
      chk({name, ".len"},   272'(line_len),   272'(el));
      chk({name, ".trunc"}, 272'(line_trunc), 272'(et));
      chk({name, ".drop"},  272'(rx_drop),    272'(ed));
   endtask

   // One clock with the given inputs; outputs are sampled 1 time unit after the edge.
   task automatic step(input logic v, input logic [7:0] d, input logic a);
      rx_valid = v;
      rx_data  = d;
      line_ack = a;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      line_ack = 1'b0;
   endtask

   task automatic send(input logic [7:0] d);
      step(1'b1, d, 1'b0);
   endtask

   function automatic vec_t mk(input logic v, input logic [7:0] d, input logic a,
                               input logic ev, input logic [5:0] el, input logic et,
                               input logic ed, input logic da, input logic [271:0] ea);
      vec_t r;
      r.v = v; r.d = d; r.a = a;
      r.e_valid = ev; r.e_len = el; r.e_trunc = et; r.e_drop = ed;
      r.do_ascii = da; r.e_ascii = ea;
      return r;
   endfunction

   initial begin
      //               v     d      a     val  len   tr   drop chkA ascii
      tbl[0]  = mk(1'b1, 8'h48, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, BLANK);
      tbl[1]  = mk(1'b1, 8'h49, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, BLANK);
      tbl[2]  = mk(1'b1, 8'h0D, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, BLANK);
      tbl[3]  = mk(1'b1, 8'h0A, 1'b0, 1'b1, 6'd2, 1'b0, 1'b0, 1'b1, HI);
      tbl[4]  = mk(1'b0, 8'h00, 1'b0, 1'b1, 6'd2, 1'b0, 1'b0, 1'b1, HI);
      tbl[5]  = mk(1'b0, 8'h00, 1'b0, 1'b1, 6'd2, 1'b0, 1'b0, 1'b1, HI);
      tbl[6]  = mk(1'b1, 8'h58, 1'b0, 1'b1, 6'd2, 1'b0, 1'b1, 1'b1, HI);
      tbl[7]  = mk(1'b1, 8'h59, 1'b0, 1'b1, 6'd2, 1'b0, 1'b1, 1'b1, HI);
      tbl[8]  = mk(1'b1, 8'h5A, 1'b1, 1'b0, 6'd0, 1'b0, 1'b1, 1'b1, BLANK);
      tbl[9]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1, BLANK);
      tbl[10] = mk(1'b1, 8'h0A, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, BLANK);
      tbl[11] = mk(1'b1, 8'h0D, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, BLANK);
      tbl[12] = mk(1'b1, 8'h0A, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, BLANK);
      tbl[13] = mk(1'b1, 8'h51, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, BLANK);
      tbl[14] = mk(1'b1, 8'h0A, 1'b0, 1'b1, 6'd1, 1'b0, 1'b0, 1'b1, LQ);
      tbl[15] = mk(1'b0, 8'h00, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1, BLANK);
      tbl[16] = mk(1'b0, 8'h00, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1, BLANK);

      rst_n    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      line_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_out("reset", 1'b0, 6'd0, 1'b0, 1'b0);
      chk("reset.ascii", line_ascii, BLANK);
      rst_n = 1'b1;
      step(1'b0, 8'h00, 1'b0);

      for (int i = 0; i < NVEC; i++) begin
         step(tbl[i].v, tbl[i].d, tbl[i].a);
         chk_out($sformatf("vec%0d", i), tbl[i].e_valid, tbl[i].e_len, tbl[i].e_trunc,
                 tbl[i].e_drop);
         if (tbl[i].do_ascii) chk($sformatf("vec%0d.ascii", i), line_ascii, tbl[i].e_ascii);
      end

      // Exactly 32 characters fit without truncation.
      repeat (32) send(8'h41);
      send(8'h0A);
      chk_out("full32", 1'b1, 6'd32, 1'b0, 1'b0);
      chk("full32.ascii", line_ascii, LA32);
      step(1'b0, 8'h00, 1'b1);

      // 40 characters: the surplus is discarded and the line is flagged.
      for (int i = 0; i < 40; i++) begin
         send(8'h41);
         if (line_valid !== 1'b0) chk($sformatf("trunc.early%0d", i), 272'(line_valid), 272'd0);
      end
      send(8'h0D);
      chk("trunc.cr_in_discard", 272'(line_valid), 272'd0);
      send(8'h0A);
      chk_out("trunc", 1'b1, 6'd32, 1'b1, 1'b0);
      chk("trunc.ascii", line_ascii, LA32);
      step(1'b0, 8'h00, 1'b0);
      chk_out("trunc.hold", 1'b1, 6'd32, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b1);
      chk_out("trunc.ack", 1'b0, 6'd0, 1'b0, 1'b0);
      chk("trunc.ack.ascii", line_ascii, BLANK);

      // Back-to-back bytes every cycle.
      send(8'h30); send(8'h31); send(8'h32); send(8'h33); send(8'h0A);
      chk_out("b2b", 1'b1, 6'd4, 1'b0, 1'b0);
      chk("b2b.ascii", line_ascii, L0123);
      step(1'b0, 8'h00, 1'b1);

      // Asynchronous reset mid-line, applied away from any clock edge.
      send(8'h41); send(8'h42);
      #10 rst_n = 1'b0;
      #1;
      chk_out("rst_mid", 1'b0, 6'd0, 1'b0, 1'b0);
      chk("rst_mid.ascii", line_ascii, BLANK);
      @(posedge clk);
      #1 rst_n = 1'b1;
      send(8'h43); send(8'h0A);
      chk_out("rst_mid.next", 1'b1, 6'd1, 1'b0, 1'b0);
      chk("rst_mid.next.ascii", line_ascii, LC);

      // Asynchronous reset while presenting, with a drop pulse in flight.
      send(8'h58);
      chk_out("pres_drop", 1'b1, 6'd1, 1'b0, 1'b1);
      #10 rst_n = 1'b0;
      #1;
      chk_out("rst_pres", 1'b0, 6'd0, 1'b0, 1'b0);
      chk("rst_pres.ascii", line_ascii, BLANK);
      @(posedge clk);
      #1 rst_n = 1'b1;
      send(8'h43); send(8'h0A);
      chk_out("rst_pres.next", 1'b1, 6'd1, 1'b0, 1'b0);
      chk("rst_pres.next.ascii", line_ascii, LC);
      step(1'b0, 8'h00, 1'b1);
      chk_out("final", 1'b0, 6'd0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_rx_line_capture.md
UART_RX_LINE_CAPTURE -- requirements
Module: uart_rx_line_capture

Interface
REQ-001 SHALL have parameter: p_term_char, default 8'h0A, line-terminator byte (LF).
REQ-002 SHALL have parameter: p_skip_char, default 8'h0D, byte discarded on receipt (CR).
REQ-003 SHALL have port: i_clk_20mhz  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port: i_rst_20mhz  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port: i_rx_data  input  8  received byte from UART RX.
REQ-006 SHALL have port: i_rx_valid  input  1  one-cycle qualifier for i_rx_data; no backpressure exists.
REQ-007 SHALL have port: o_line_ascii  output  272  34-byte line; byte 0 (first char) in [271:264].
REQ-008 SHALL have port: o_line_valid  output  1  completed line held on o_line_ascii.
REQ-009 SHALL have port: i_line_ack  input  1  consumer release of presented line.
REQ-010 SHALL have port: o_line_len  output  6  count of stored payload chars, 0..32.
REQ-011 SHALL have port: o_line_trunc  output  1  presented line lost characters past 32.
REQ-012 SHALL have port: o_rx_drop  output  1  one-cycle pulse per byte discarded while a line is presented.

Function
REQ-013 SHALL implement FSM states ST_RXLINE_ACCUM, ST_RXLINE_DISCARD, ST_RXLINE_PRESENT; all outputs registered.
REQ-014 SHALL hold a 34-byte line buffer driven directly onto o_line_ascii; bytes 32..33 always 8'h0D, 8'h0A; bytes 0..31 cleared to 8'h20 on every entry to ACCUM.
REQ-015 ACCUM, i_rx_valid with byte == p_skip_char: byte ignored, no state or count change.
REQ-016 ACCUM, i_rx_valid with byte == p_term_char and count == 0: ignored (empty lines are not presented).
REQ-017 ACCUM, i_rx_valid with byte == p_term_char and count > 0: next cycle -> PRESENT, o_line_valid = 1, o_line_len = count, o_line_trunc = 0.
REQ-018 ACCUM, other byte with count < 32: byte written to buffer index count, count += 1 (6-bit, never exceeds 32).
REQ-019 ACCUM, other byte with count == 32: byte discarded, -> DISCARD.
REQ-020 DISCARD: all bytes except p_term_char discarded silently; p_term_char -> PRESENT with o_line_len = 32, o_line_trunc = 1.
REQ-021 Latency: terminator accepted on cycle N yields o_line_valid = 1 on cycle N+1.
REQ-022 PRESENT: o_line_valid, o_line_ascii, o_line_len, o_line_trunc held stable until i_line_ack = 1 is sampled.
REQ-023 PRESENT with i_line_ack = 1: next cycle o_line_valid = 0, o_line_trunc = 0, o_line_len = 0, buffer cleared, -> ACCUM.
REQ-024 PRESENT with i_rx_valid = 1 (including the ack cycle): byte discarded and o_rx_drop = 1 on the next cycle.
REQ-025 i_line_ack outside PRESENT SHALL be ignored.
REQ-026 Unreachable state encodings SHALL recover to ACCUM with cleared buffer.

Reset
REQ-027 Reset assertion SHALL immediately, independent of clock, force ACCUM, count 0, buffer to twenty-thirty-two 8'h20 + 8'h0D 8'h0A, o_line_valid 0, o_line_len 0, o_line_trunc 0, o_rx_drop 0.
REQ-028 Reset asserted mid-line or mid-present SHALL discard all partial or pending data; first post-release byte starts a new line.

Verification
REQ-029 Bytes "HI",0x0D,0x0A -> one cycle after LF o_line_valid = 1, o_line_len = 2, o_line_ascii = 0x4849 + thirty 0x20 + 0x0D0A; held until ack.
REQ-030 40 chars 'A' then LF -> o_line_len = 32, o_line_trunc = 1, bytes 0..31 = 0x41, bytes 32..33 = 0x0D0A.
REQ-031 Lone LF, then CR,LF -> o_line_valid stays 0 throughout.
REQ-032 While presented, 3 bytes "XYZ" sent, ack asserted with the third -> three o_rx_drop pulses, line unchanged; after ack o_line_valid = 0 and next line "Q",LF presents o_line_len = 1, byte 0 = 0x51, bytes 1..31 = 0x20.
REQ-033 Reset asserted after "AB" and again while presenting -> outputs return to reset values asynchronously; subsequent "C",LF presents o_line_len = 1 with byte 0 = 0x43.
REQ-034 Back-to-back i_rx_valid every cycle for "0123",LF -> no byte lost, o_line_ascii bytes 0..3 = 0x30313233.
